imm_gen_stage: RTL
==================

// Module: imm_gen_stage
// PURPOSE
//  Pipelined, handshaked RISC-V immediate generator for all base formats (I/S/B/U/J).
//  Sits between fetch/IR and the register-read stage of the datapath.
//  Decodes the opcode, builds the sign-extended XLEN immediate and tags the format.
//  Unknown opcodes raise an illegal flag. Backpressure and flush are supported.
// PARAMETERS
//  XLEN    64  immediate/output width; 32 or 64 only.
//  STAGES  1   register stages between input and output; 1..3.
// PORTS
//  clk        in   1     clock; all state changes on posedge.
//  reset      in   1     synchronous, active-high reset.
//  flush      in   1     synchronous squash of every in-flight entry.
//  in_valid   in   1     instruction on in_instr is valid.
//  in_ready   out  1     stage can accept this cycle.
//  in_instr   in   32    raw instruction word.
//  out_valid  out  1     out_* fields are valid.
//  out_ready  in   1     consumer accepts this cycle.
//  out_imm    out  XLEN  sign-extended immediate.
//  out_fmt    out  3     format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
//  out_illegal out 1     opcode not in the supported set.
//  out_instr  out  32    instruction passed through, aligned with out_imm.
// BEHAVIOUR
//  - Reset (synchronous, active-high): all stage valids 0; out_imm/out_fmt/out_instr 0; out_illegal 0.
//  - Transfer: in_valid & in_ready. Output retire: out_valid & out_ready.
//  - Each stage k holds {valid,instr,imm,fmt,illegal}. Stage k loads when its downstream slot is free or draining:
//    ready_k = !valid_k | ready_{k+1}; ready_{STAGES} = out_ready. in_ready = ready_0 (combinational, no bubble).
//  - Latency: exactly STAGES cycles from accept to out_valid with out_ready held 1. Throughput: 1 per cycle.
//  - Stall: out_valid=1 and out_ready=0 -> all out_* held stable; upstream stages fill, then in_ready=0.
//  - Decode is combinational on in_instr, registered into stage 0; later stages copy unchanged.
//  - Opcode map (inst[6:0]):
//    I: 0000011, 0010011, 1100111, 0011011 (XLEN=64 only), 1110011.
//    S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
//    R: 0110011, 0111011 (XLEN=64 only) -> imm 0.
//    Any other opcode -> fmt 0, imm 0, illegal 1.
//  - Immediates, sign bit is inst[31] in all formats, extended to XLEN:
//    I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0};
//    U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
//  - XLEN=32: opcodes 0011011/0111011 are illegal.
//  - Flush: all valids cleared next edge; data fields need not clear. A transfer in the same cycle is dropped.
//    in_ready may be 1 during flush.
//  - Reset has priority over flush. Reset mid-stream discards all entries; no partial output.
//  - Upstream must hold in_instr stable while in_valid=1 and in_ready=0; out_* obey the same rule.
// STRUCTURE
//  - Package riscv_imm_pkg: opcode localparams, fmt_e encoding (3 bits), function sext(value, width).
//  - Sub-module imm_decode_comb (combinational): inst[31:0] -> {imm, fmt, illegal}, parametrised by XLEN.
//    Instantiated once, before stage 0.
//  - Stage registers: generate loop over STAGES with a packed entry struct; no FIFO/RAM.
// TESTING (XLEN=64, STAGES=2 unless noted; out_ready=1 unless noted)
//  1. addi 0xFFE00013, sw 0xFE002F23, beq 0xFE000CE3 back to back
//     -> imm 0xFFFF_FFFF_FFFF_FFFE, 0x...FFFE, 0x...FFF8; fmt 1, 2, 3; out_valid on cycles 2, 3, 4.
//  2. lui 0x123450B7 -> imm 0x0000_0000_1234_5000, fmt 4.
//     lui 0x800000B7 -> 0xFFFF_FFFF_8000_0000.
//     jal 0xFFDFF06F -> imm -4, fmt 5.
//  3. Hold out_ready=0 for 5 cycles while streaming 4 instrs
//     -> in_ready drops after 2 accepted; out_* stable; on release all 4 emerge in order, no loss or duplicate.
//  4. Opcode 0x0000007F -> illegal=1, imm 0.
//     XLEN=32: addiw 0x0010009B -> illegal=1; addi -2 -> 0xFFFF_FFFE.
//  5. flush with 2 entries in flight plus a simultaneous transfer -> out_valid=0 next cycle, nothing emerges later.
//  6. reset asserted mid-stream for 1 cycle -> all outputs 0 next edge; the next instr appears after STAGES cycles.
//     Repeat test 1 with STAGES=1 and STAGES=3 -> latency 1 and 3.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V opcode constants, immediate format tags and a sign-extension helper
// used by the immediate-generation pipeline.
package riscv_imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Treats bit (width-1) of value as the sign and replicates it up to 64 bits.
  function automatic logic [63:0] sext(input logic [31:0] value, input int unsigned width);
    logic signed [63:0] shifted;
    shifted = $signed({32'd0, value} << (64 - width));
    return $unsigned(shifted >>> (64 - width));
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RISC-V immediate decoder: opcode -> format tag, sign-extended
// immediate and an illegal flag for opcodes outside the supported base set.
module imm_decode_comb
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [63:0] imm_full;

  always_comb begin
    imm_full = '0;
    fmt      = FMT_R;
    illegal  = 1'b0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        fmt      = FMT_I;
        imm_full = sext({20'd0, inst[31:20]}, 12);
      end
      // The word-sized variants only exist on RV64.
      OP_IMM32: begin
        if (XLEN == 64) begin
          fmt      = FMT_I;
          imm_full = sext({20'd0, inst[31:20]}, 12);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        fmt      = FMT_S;
        imm_full = sext({20'd0, inst[31:25], inst[11:7]}, 12);
      end
      OP_BRANCH: begin
        fmt      = FMT_B;
        imm_full = sext({19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
      end
      OP_LUI, OP_AUIPC: begin
        fmt      = FMT_U;
        imm_full = sext({inst[31:12], 12'd0}, 32);
      end
      OP_JAL: begin
        fmt      = FMT_J;
        imm_full = sext({11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
      end
      OP_OP: begin
        fmt = FMT_R;
      end
      OP_OP32: begin
        illegal = (XLEN != 64);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined, valid/ready handshaked immediate generator. Decode happens before
// stage 0; later stages are plain skid-free register slices with flush.
module imm_gen_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;
  logic [STAGES:0] ready;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst    (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry     = '{instr: in_instr, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};
  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic   valid_reg;
    entry_t data_reg;
    logic   src_valid;
    entry_t src_data;

    if (gi == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = dec_entry;
    end else begin : g_tail
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_data  = g_stage[gi-1].data_reg;
    end

    // A slot can take new data when empty or when its occupant leaves this cycle.
    assign ready[gi] = !valid_reg || ready[gi+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (flush) begin
        valid_reg <= 1'b0;
      end else if (ready[gi]) begin
        valid_reg <= src_valid;
        data_reg  <= src_data;
      end
    end
  end

  assign out_valid   = g_stage[STAGES-1].valid_reg;
  assign out_imm     = g_stage[STAGES-1].data_reg.imm;
  assign out_fmt     = g_stage[STAGES-1].data_reg.fmt;
  assign out_illegal = g_stage[STAGES-1].data_reg.illegal;
  assign out_instr   = g_stage[STAGES-1].data_reg.instr;

endmodule
